// File: rtl/reg_arb_pkg.sv
// Shared types, default sizing and helpers for the shared-register arbiter.
package reg_arb_pkg;

    // Largest requester count the arbiter supports
    localparam int MAX_NREQ     = 8;

    // Default sizing used by the top level
    localparam int DEF_NREQ     = 4;
    localparam int DEF_WIDTH    = 4;
    localparam int DEF_MAX_HOLD = 3;

    // IDLE: no grant issued last cycle; OWNED: a requester holds the register
    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // Turn a requester index into a one-hot vector sized for the largest supported arbiter
    function automatic logic [MAX_NREQ-1:0] onehot(input logic [2:0] idx);
        logic [MAX_NREQ-1:0] vec;
        vec = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first set request bit at or after ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    // Scan from ptr upward; the first hit wins, later hits are ignored
    always_comb begin
        int cand;
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NREQ requesters,
// with a bounded lock that lets the current owner keep the register for up to MAX_HOLD cycles.
module reg_share_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*WIDTH-1:0]    wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic [$clog2(NREQ)-1:0]  owner
);

    localparam int IW  = $clog2(NREQ);
    // Keep the hold counter at least one bit wide even when MAX_HOLD is 1
    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [IW-1:0]  LAST_IDX  = IW'(NREQ - 1);

    arb_state_t      state;
    logic [IW-1:0]   ptr;
    logic [HCW-1:0]  hold_cnt;

    logic            rr_found;
    logic [IW-1:0]   rr_idx;
    logic            keep;
    logic            win_valid;
    logic [IW-1:0]   win_idx;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .found (rr_found),
        .idx   (rr_idx)
    );

    // Decide this cycle's winner: a locking owner under its cap keeps the register, else round-robin
    always_comb begin
        keep      = (state == OWNED) && req[owner] && lock[owner] && (hold_cnt < HOLD_LAST);
        win_valid = keep || rr_found;
        win_idx   = keep ? owner : rr_idx;
    end

    // Register the winner's data, grant and bookkeeping; idle cycles hold q, owner and ptr
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt      <= '0;
            q        <= '0;
            q_valid  <= 1'b0;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            state    <= IDLE;
        end else if (win_valid) begin
            q       <= wdata[int'(win_idx)*WIDTH +: WIDTH];
            gnt     <= NREQ'(onehot(3'(win_idx)));
            owner   <= win_idx;
            q_valid <= 1'b1;
            state   <= OWNED;
            if (keep) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
                ptr      <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            end
        end else begin
            gnt      <= '0;
            q_valid  <= 1'b0;
            hold_cnt <= '0;
            state    <= IDLE;
        end
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed scoreboard bench for reg_share_arbiter with default sizing (4 requesters, 4-bit data, hold cap 3).
module tb_reg_share_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [15:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  q;
    logic        q_valid;
    logic [1:0]  owner;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] gnt;
        logic [3:0] q;
        logic       qv;
        logic [1:0] owner;
        string      tag;
    } exp_t;

    exp_t sb[$];

    reg_share_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lock    (lock),
        .wdata   (wdata),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .owner   (owner)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop the oldest expectation and compare every output against it
    task automatic checkOutput();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1 entries");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (gnt === e.gnt) else begin
                errors++;
                $error("[TB] FAIL %s.gnt observed=%b expected=%b", e.tag, gnt, e.gnt);
            end
            checks++;
            assert (q === e.q) else begin
                errors++;
                $error("[TB] FAIL %s.q observed=%b expected=%b", e.tag, q, e.q);
            end
            checks++;
            assert (q_valid === e.qv) else begin
                errors++;
                $error("[TB] FAIL %s.q_valid observed=%b expected=%b", e.tag, q_valid, e.qv);
            end
            checks++;
            assert (owner === e.owner) else begin
                errors++;
                $error("[TB] FAIL %s.owner observed=%0d expected=%0d", e.tag, owner, e.owner);
            end
        end
    endtask

    // Drive one cycle of inputs, record what the DUT must show after the next edge, then check it
    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                                 input logic [15:0] wd, input logic [3:0] eg, input logic [3:0] eq,
                                 input logic eqv, input logic [1:0] eo, input string tag);
        exp_t e;
        rst   = r;
        req   = rq;
        lock  = lk;
        wdata = wd;
        e.gnt   = eg;
        e.q     = eq;
        e.qv    = eqv;
        e.owner = eo;
        e.tag   = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    localparam logic [15:0] WD_SINGLE = {4'b0000, 4'b1010, 4'b0000, 4'b0000};
    localparam logic [15:0] WD_RR     = {4'd4, 4'd3, 4'd2, 4'd1};
    localparam logic [15:0] WD_LOCK   = {4'b0000, 4'b0000, 4'b0011, 4'b1100};
    localparam logic [15:0] WD_FULL   = {4'b0000, 4'b0000, 4'b0000, 4'b1111};
    localparam logic [15:0] WD_LAST   = {4'b0101, 4'b0000, 4'b0000, 4'b0000};

    // Linear sequence of directed steps
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = '0;
        lock   = '0;
        wdata  = '0;
        #1;

        // Reset dominates active requests and locks
        applyStimulus(1'b1, 4'b1111, 4'b1111, WD_RR, 4'b0000, 4'b0000, 1'b0, 2'd0, "reset_c1");
        applyStimulus(1'b1, 4'b1111, 4'b1111, WD_RR, 4'b0000, 4'b0000, 1'b0, 2'd0, "reset_c2");

        // Single requester
        applyStimulus(1'b0, 4'b0100, 4'b0000, WD_SINGLE, 4'b0100, 4'b1010, 1'b1, 2'd2, "single");

        // Round robin from a fresh pointer
        applyStimulus(1'b1, 4'b0000, 4'b0000, WD_RR, 4'b0000, 4'b0000, 1'b0, 2'd0, "rr_reset");
        applyStimulus(1'b0, 4'b1111, 4'b0000, WD_RR, 4'b0001, 4'b0001, 1'b1, 2'd0, "rr_0");
        applyStimulus(1'b0, 4'b1111, 4'b0000, WD_RR, 4'b0010, 4'b0010, 1'b1, 2'd1, "rr_1");
        applyStimulus(1'b0, 4'b1111, 4'b0000, WD_RR, 4'b0100, 4'b0011, 1'b1, 2'd2, "rr_2");
        applyStimulus(1'b0, 4'b1111, 4'b0000, WD_RR, 4'b1000, 4'b0100, 1'b1, 2'd3, "rr_3");
        applyStimulus(1'b0, 4'b1111, 4'b0000, WD_RR, 4'b0001, 4'b0001, 1'b1, 2'd0, "rr_wrap");

        // Lock cap: owner 0 keeps for three grants, then requester 1, then back to 0
        applyStimulus(1'b1, 4'b0000, 4'b0000, WD_LOCK, 4'b0000, 4'b0000, 1'b0, 2'd0, "cap_reset");
        applyStimulus(1'b0, 4'b0011, 4'b0001, WD_LOCK, 4'b0001, 4'b1100, 1'b1, 2'd0, "cap_h0");
        applyStimulus(1'b0, 4'b0011, 4'b0001, WD_LOCK, 4'b0001, 4'b1100, 1'b1, 2'd0, "cap_h1");
        applyStimulus(1'b0, 4'b0011, 4'b0001, WD_LOCK, 4'b0001, 4'b1100, 1'b1, 2'd0, "cap_h2");
        applyStimulus(1'b0, 4'b0011, 4'b0001, WD_LOCK, 4'b0010, 4'b0011, 1'b1, 2'd1, "cap_other");
        applyStimulus(1'b0, 4'b0011, 4'b0001, WD_LOCK, 4'b0001, 4'b1100, 1'b1, 2'd0, "cap_back");

        // Reset in the middle of a hold restarts arbitration from requester 0
        applyStimulus(1'b1, 4'b0000, 4'b0000, WD_LOCK, 4'b0000, 4'b0000, 1'b0, 2'd0, "mid_pre");
        applyStimulus(1'b0, 4'b0011, 4'b0001, WD_LOCK, 4'b0001, 4'b1100, 1'b1, 2'd0, "mid_h0");
        applyStimulus(1'b1, 4'b0011, 4'b0001, WD_LOCK, 4'b0000, 4'b0000, 1'b0, 2'd0, "mid_rst");
        applyStimulus(1'b0, 4'b0011, 4'b0000, WD_LOCK, 4'b0001, 4'b1100, 1'b1, 2'd0, "mid_rr0");
        applyStimulus(1'b0, 4'b0011, 4'b0000, WD_LOCK, 4'b0010, 4'b0011, 1'b1, 2'd1, "mid_rr1");

        // Idle cycles hold q and owner while gnt and q_valid drop
        applyStimulus(1'b0, 4'b0001, 4'b0000, WD_FULL, 4'b0001, 4'b1111, 1'b1, 2'd0, "idle_load");
        applyStimulus(1'b0, 4'b0000, 4'b0000, WD_FULL, 4'b0000, 4'b1111, 1'b0, 2'd0, "idle_1");
        applyStimulus(1'b0, 4'b0000, 4'b0000, WD_FULL, 4'b0000, 4'b1111, 1'b0, 2'd0, "idle_2");
        applyStimulus(1'b0, 4'b0000, 4'b0000, WD_FULL, 4'b0000, 4'b1111, 1'b0, 2'd0, "idle_3");
        applyStimulus(1'b0, 4'b1000, 4'b0000, WD_LAST, 4'b1000, 4'b0101, 1'b1, 2'd3, "idle_wake");

        // Sole locking requester is re-granted across the hold cap
        applyStimulus(1'b0, 4'b1000, 4'b1000, WD_LAST, 4'b1000, 4'b0101, 1'b1, 2'd3, "sole_h1");
        applyStimulus(1'b0, 4'b1000, 4'b1000, WD_LAST, 4'b1000, 4'b0101, 1'b1, 2'd3, "sole_h2");
        applyStimulus(1'b0, 4'b1000, 4'b1000, WD_LAST, 4'b1000, 4'b0101, 1'b1, 2'd3, "sole_recap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
Round-robin arbiter that shares a single WIDTH-bit D-type storage register among NREQ requesters. Each cycle it selects at most one requester and captures that requester's write data into the register. It reports the winner with a one-hot grant. An owner may lock the register for up to MAX_HOLD consecutive cycles. The block sits between several producer blocks and the register, and owns both sequencing and arbitration.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 4, register data width
MAX_HOLD, 3, max consecutive grants to one locking owner (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  NREQ  per-requester write request
lock  input  NREQ  per-requester hold request; only meaningful for the current owner
wdata  input  NREQ*WIDTH  flattened write data; requester i is on bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  registered one-hot grant; zero when idle
q  output  WIDTH  shared register contents
q_valid  output  1  high in the cycle after an edge that wrote q
owner  output  $clog2(NREQ)  index of last granted requester

Behaviour:
- Single clock clk. Reset is synchronous, active-high on rst, and dominates all other inputs.
- Reset values: gnt=0, q=0, q_valid=0, owner=0, ptr=0, hold_cnt=0, state=IDLE.
- Internal state:
  - ptr: round-robin start index.
  - hold_cnt: 0..MAX_HOLD-1.
  - state: IDLE or OWNED.
- Grant decision is combinational on current inputs/state. gnt, q, q_valid and owner all update at the same rising edge (latency 1).
- Keep rule: state==OWNED and req[owner] and lock[owner] and hold_cnt < MAX_HOLD-1.
  - Winner = owner; hold_cnt increments.
- Otherwise, round-robin: winner = first i with req[i]=1, scanning ptr, ptr+1, ..., wrapping modulo NREQ.
  - hold_cnt resets to 0.
  - ptr <= (winner+1) mod NREQ. Wrap from NREQ-1 goes to 0.
- When a winner w exists:
  - q <= wdata[w]
  - gnt <= onehot(w)
  - owner <= w
  - q_valid <= 1
  - state <= OWNED
- When no request exists:
  - gnt <= 0, q_valid <= 0, state <= IDLE.
  - q, owner and ptr hold.
- Lock cap: after MAX_HOLD consecutive grants to a locking owner, the next decision is round-robin starting at owner+1. If the owner is the only requester, it wins again with hold_cnt=0, so it is never starved.
- lock from non-owners is ignored. lock with req low is ignored.
- Owner drops req while locked: the next decision is round-robin from ptr.
- Reset mid-hold: the next edge clears everything. Arbitration restarts from ptr=0.
- gnt is always one-hot or zero. q_valid==|gnt always.
- No combinational path from inputs to outputs.

Decomposition:
- Package reg_arb_pkg holds:
  - state enum (IDLE, OWNED)
  - default NREQ/WIDTH/MAX_HOLD constants
  - onehot encode helper function
- One sub-module: rr_pick.
  - Purely combinational.
  - Inputs req and ptr; outputs found and idx of the first set bit at or after ptr, with wrap.
- The top level holds the FSM, hold counter, pointer and data register.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=4'b1111, lock=4'b1111 -> gnt=0, q=4'b0000, q_valid=0, owner=0 throughout.
2. Single request: req=4'b0100, wdata[2]=4'b1010 -> after one edge gnt=4'b0100, q=4'b1010, owner=2, q_valid=1.
3. Round robin: req=4'b1111, lock=0, wdata[i]=i+1 -> gnt sequence 0001,0010,0100,1000,0001; q sequence 0001,0010,0011,0100,0001.
4. Lock cap: req=4'b0011, lock=4'b0001, MAX_HOLD=3, wdata0=4'b1100, wdata1=4'b0011.
   - gnt = 0001 for 3 cycles (q=1100), then 0010 (q=0011), then 0001 again.
5. Reset mid-hold: during step 4's second locked cycle assert rst=1 for one cycle -> gnt=0, q=0.
   - Then req=4'b0011, lock=0 -> gnt=0001, then 0010.
6. Idle and hold: after q=4'b1111, drive req=0 for 3 cycles -> gnt=0, q_valid=0, q stays 4'b1111.
   - Then req=4'b1000 -> gnt=1000 on the next edge.
